qspi_flash_responder: RTL and testbench

Synthesizable QSPI flash responder: the flash-side end of the quad-read link driven by the cache's QSPI read controller. It decodes the serial command and quad address from the controller, waits out the mode and dummy phases, then streams bytes fetched from a synchronous byte-wide memory as nibbles until chip select rises. It serves as the flash model in system simulation and as an on-chip flash emulator in FPGA bring-up, running on the same `clk` as the controller with no separate SPI clock.

---
 rtl/qspi_flash_responder_if.sv | 42 ++++
 rtl/qspi_flash_responder.sv | 168 ++++++++++++++++
 tb/tb_qspi_flash_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_flash_responder_if.sv
// ============================================================================
//  Module      : qspi_flash_responder_if
//  Description : Bus bundle between a QSPI read controller (plus its backing
//                byte memory) and the flash responder.
//                  csb       - chip select, active low (controller)
//                  io_in     - controller-driven bus lines, bit 0 = command
//                  io_out    - responder data nibble
//                  io_oe     - responder output enable (all bits equal)
//                  mem_addr  - byte address to memory
//                  mem_re    - memory read strobe
//                  mem_rdata - memory data, valid one cycle after mem_re
//                  busy      - responder not idle
//                  err       - one-cycle pulse on a rejected opcode
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface qspi_flash_responder_if;
    logic        csb;
    logic [3:0]  io_in;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic [23:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        err;

    // Controller side, which also owns the memory data return path.
    modport master (
        output csb, io_in, mem_rdata,
        input  io_out, io_oe, mem_addr, mem_re, busy, err
    );

    // Flash responder side.
    modport slave (
        input  csb, io_in, mem_rdata,
        output io_out, io_oe, mem_addr, mem_re, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/qspi_flash_responder.sv
// ============================================================================
//  Module      : qspi_flash_responder
//  Description : Flash-side end of a quad-read QSPI link. Decodes a serial
//                opcode and a quad 24-bit address, skips the mode and dummy
//                phases, then streams bytes fetched from a synchronous
//                byte-wide memory as high/low nibbles until csb rises.
//  Ports       : clk    - system clock, also the bus bit clock
//                rst_n  - asynchronous active-low reset
//                bus    - qspi_flash_responder_if.slave bundle
//  Parameters  : CMD          - accepted read opcode
//                DUMMY_CYCLES - bus cycles between mode and first nibble (1..15)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qspi_flash_responder #(
    parameter logic [7:0] CMD          = 8'hEB,
    parameter int         DUMMY_CYCLES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    qspi_flash_responder_if.slave bus
);

    localparam logic [3:0] C_CMD_LAST   = 4'd7;
    localparam logic [3:0] C_ADDR_LAST  = 4'd5;
    localparam logic [3:0] C_DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_MODE   = 3'd3,
        S_DUMMY  = 3'd4,
        S_DATA   = 3'd5,
        S_REJECT = 3'd6
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;       // phase counter; in DATA bit 0 selects the low nibble
    logic [6:0]  r_op;        // opcode bits collected so far
    logic [23:0] r_addr;      // addr_q
    logic [7:0]  r_data;      // data_q
    logic        r_mem_re;
    logic [23:0] r_mem_addr;
    logic        r_err;

    logic [7:0]  w_op;
    logic [23:0] w_addr;
    logic [23:0] w_addr_inc;
    logic        w_drive;

    // Opcode/address as they stand once the current bus sample is included.
    assign w_op       = {r_op, bus.io_in[0]};
    assign w_addr     = {r_addr[19:0], bus.io_in};
    assign w_addr_inc = r_addr + 24'd1;

    // Gated on csb directly so the bus is released in the cycle csb rises.
    assign w_drive    = (r_state == S_DATA) && !bus.csb;

    assign bus.io_oe    = {4{w_drive}};
    assign bus.io_out   = w_drive ? (r_cnt[0] ? r_data[3:0] : r_data[7:4]) : 4'h0;
    assign bus.mem_re   = r_mem_re;
    assign bus.mem_addr = r_mem_addr;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.err      = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_op       <= 7'd0;
            r_addr     <= 24'd0;
            r_data     <= 8'd0;
            r_mem_re   <= 1'b0;
            r_mem_addr <= 24'd0;
            r_err      <= 1'b0;
        end else if (bus.csb) begin
            // Deselect aborts whatever was in flight; partial contents are
            // simply overwritten by the next transaction.
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_mem_re <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // First low cycle carries opcode bit 7.
                    r_op    <= {6'd0, bus.io_in[0]};
                    r_cnt   <= 4'd1;
                    r_state <= S_CMD;
                end
                S_CMD: begin
                    r_op <= w_op[6:0];
                    if (r_cnt == C_CMD_LAST) begin
                        r_cnt <= 4'd0;
                        if (w_op == CMD) begin
                            r_state <= S_ADDR;
                        end else begin
                            r_state <= S_REJECT;
                            r_err   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_ADDR: begin
                    r_addr <= w_addr;
                    if (r_cnt == C_ADDR_LAST) begin
                        // Launch the first fetch so it is back by the end of MODE.
                        r_cnt      <= 4'd0;
                        r_state    <= S_MODE;
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= w_addr;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_MODE: begin
                    if (!r_cnt[0]) begin
                        r_mem_re <= 1'b0;
                        r_cnt    <= 4'd1;
                    end else begin
                        r_data  <= bus.mem_rdata;
                        r_addr  <= w_addr_inc;
                        r_cnt   <= 4'd0;
                        r_state <= S_DUMMY;
                    end
                end
                S_DUMMY: begin
                    if (r_cnt == C_DUMMY_LAST) begin
                        // Prefetch the next byte during the first high nibble.
                        r_cnt      <= 4'd0;
                        r_state    <= S_DATA;
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= r_addr;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DATA: begin
                    if (!r_cnt[0]) begin
                        r_mem_re <= 1'b0;
                        r_cnt    <= 4'd1;
                    end else begin
                        // data_q still drives the low nibble this cycle; the
                        // fetched byte replaces it at the edge.
                        r_data     <= bus.mem_rdata;
                        r_addr     <= w_addr_inc;
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= w_addr_inc;
                        r_cnt      <= 4'd0;
                    end
                end
                S_REJECT: begin
                    r_state <= S_REJECT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_qspi_flash_responder.sv
// ============================================================================
//  Module      : tb_qspi_flash_responder
//  Description : Directed self-checking bench for qspi_flash_responder.
//                Three responders (DUMMY_CYCLES 4, 1, 15) share csb/io_in;
//                each has its own byte memory with mem[a] = a[7:0] ^ 8'hA5.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qspi_flash_responder;

    logic       clk;
    logic       rst_n;
    logic       csb;
    logic [3:0] io_in;

    int checks;
    int errors;
    int cyc;
    int first1, first4, first15;
    logic [3:0] nib1, nib15;

    qspi_flash_responder_if bus4 ();
    qspi_flash_responder_if bus1 ();
    qspi_flash_responder_if bus15 ();

    assign bus4.csb   = csb;
    assign bus4.io_in = io_in;
    assign bus1.csb   = csb;
    assign bus1.io_in = io_in;
    assign bus15.csb   = csb;
    assign bus15.io_in = io_in;

    qspi_flash_responder #(.CMD(8'hEB), .DUMMY_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );
    qspi_flash_responder #(.CMD(8'hEB), .DUMMY_CYCLES(1)) u_dut_d1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    qspi_flash_responder #(.CMD(8'hEB), .DUMMY_CYCLES(15)) u_dut_d15 (
        .clk(clk), .rst_n(rst_n), .bus(bus15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [23:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) if (bus4.mem_re)  bus4.mem_rdata  <= mem_val(bus4.mem_addr);
    always @(posedge clk) if (bus1.mem_re)  bus1.mem_rdata  <= mem_val(bus1.mem_addr);
    always @(posedge clk) if (bus15.mem_re) bus15.mem_rdata <= mem_val(bus15.mem_addr);

    // Records the first driven cycle of each responder within a transaction.
    always @(negedge clk) begin
        if (!csb && cyc >= 0) begin
            if (bus1.io_oe == 4'hF && first1 < 0) begin
                first1 = cyc;
                nib1   = bus1.io_out;
            end
            if (bus4.io_oe == 4'hF && first4 < 0) first4 = cyc;
            if (bus15.io_oe == 4'hF && first15 < 0) begin
                first15 = cyc;
                nib15   = bus15.io_out;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive after the rising edge, return at the falling edge.
    task automatic step(input logic c, input logic [3:0] d);
        @(posedge clk);
        #1;
        csb   = c;
        io_in = d;
        cyc   = c ? -1 : cyc + 1;
        @(negedge clk);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_oe"},    32'(bus4.io_oe),    32'h0);
        chk({tag, "_out"},   32'(bus4.io_out),   32'h0);
        chk({tag, "_re"},    32'(bus4.mem_re),   32'h0);
        chk({tag, "_maddr"}, 32'(bus4.mem_addr), 32'h0);
        chk({tag, "_busy"},  32'(bus4.busy),     32'h0);
        chk({tag, "_err"},   32'(bus4.err),      32'h0);
    endtask

    task automatic send_cmd(input logic [7:0] op);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, {3'b000, op[i]});
            chk("cmd_oe", 32'(bus4.io_oe),  32'h0);
            chk("cmd_re", 32'(bus4.mem_re), 32'h0);
        end
    endtask

    task automatic send_addr_mode(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) begin
            step(1'b0, a[i*4 +: 4]);
            chk("addr_oe", 32'(bus4.io_oe), 32'h0);
        end
        step(1'b0, 4'h0);
        chk("mode1_re",   32'(bus4.mem_re),   32'h1);
        chk("mode1_addr", 32'(bus4.mem_addr), 32'(a));
        step(1'b0, 4'h0);
        chk("mode2_oe", 32'(bus4.io_oe), 32'h0);
    endtask

    task automatic dummy4();
        repeat (4) begin
            step(1'b0, 4'h0);
            chk("dummy_oe", 32'(bus4.io_oe), 32'h0);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] b);
        step(1'b0, 4'h0);
        chk({tag, "_oe_hi"}, 32'(bus4.io_oe),  32'hF);
        chk({tag, "_hi"},    32'(bus4.io_out), 32'(b[7:4]));
        step(1'b0, 4'h0);
        chk({tag, "_oe_lo"}, 32'(bus4.io_oe),  32'hF);
        chk({tag, "_lo"},    32'(bus4.io_out), 32'(b[3:0]));
    endtask

    initial begin
        checks = 0; errors = 0; cyc = -1;
        first1 = -1; first4 = -1; first15 = -1;
        nib1 = 4'h0; nib15 = 4'h0;
        rst_n = 1'b0; csb = 1'b1; io_in = 4'h0;

        // Reset state
        repeat (3) step(1'b1, 4'h0);
        chk_cleared("reset");
        rst_n = 1'b1;
        step(1'b1, 4'h0);

        // Basic read at 0x001234: bytes 91 90 93 92, first nibble on cycle 20
        send_cmd(8'hEB);
        chk("cmd_busy", 32'(bus4.busy), 32'h1);
        send_addr_mode(24'h001234);
        dummy4();
        check_byte("basic0", 8'h91);
        check_byte("basic1", 8'h90);
        check_byte("basic2", 8'h93);
        check_byte("basic3", 8'h92);
        step(1'b1, 4'h0);
        chk("basic_end_oe",  32'(bus4.io_oe),  32'h0);
        chk("basic_end_out", 32'(bus4.io_out), 32'h0);

        // Bad opcode 03: single err pulse in cycle 8, no drive, no reads
        send_cmd(8'h03);
        step(1'b0, 4'hF);
        chk("bad_err",  32'(bus4.err),  32'h1);
        chk("bad_busy", 32'(bus4.busy), 32'h1);
        chk("bad_re",   32'(bus4.mem_re), 32'h0);
        repeat (6) begin
            step(1'b0, 4'hF);
            chk("bad_err_once", 32'(bus4.err),    32'h0);
            chk("bad_oe",       32'(bus4.io_oe),  32'h0);
            chk("bad_re",       32'(bus4.mem_re), 32'h0);
        end
        step(1'b1, 4'h0);
        send_cmd(8'hEB);
        send_addr_mode(24'h0000AB);
        dummy4();
        check_byte("after_bad", 8'h0E);
        step(1'b1, 4'h0);

        // Address wrap at 0xFFFFFF: bytes 5A then A5, fetch of 000000
        send_cmd(8'hEB);
        send_addr_mode(24'hFFFFFF);
        dummy4();
        step(1'b0, 4'h0);
        chk("wrap_hi0",   32'(bus4.io_out),   32'h5);
        chk("wrap_re",    32'(bus4.mem_re),   32'h1);
        chk("wrap_maddr", 32'(bus4.mem_addr), 32'h000000);
        step(1'b0, 4'h0);
        chk("wrap_lo0", 32'(bus4.io_out), 32'hA);
        check_byte("wrap1", 8'hA5);
        step(1'b1, 4'h0);

        // Early deassert mid-ADDR, then a read at 0x000010
        send_cmd(8'hEB);
        repeat (3) begin
            step(1'b0, 4'h0);
            chk("abort_addr_oe", 32'(bus4.io_oe), 32'h0);
        end
        step(1'b1, 4'h0);
        chk("abort_oe", 32'(bus4.io_oe), 32'h0);
        send_cmd(8'hEB);
        send_addr_mode(24'h000010);
        dummy4();
        check_byte("after_abort", 8'hB5);
        step(1'b1, 4'h0);

        // csb rises in a low-nibble cycle: bus released in that same cycle
        send_cmd(8'hEB);
        send_addr_mode(24'h000020);
        dummy4();
        step(1'b0, 4'h0);
        chk("mid_hi", 32'(bus4.io_out), 32'h8);
        step(1'b1, 4'h0);
        chk("mid_oe",  32'(bus4.io_oe),  32'h0);
        chk("mid_out", 32'(bus4.io_out), 32'h0);
        step(1'b1, 4'h0);
        chk("mid_idle", 32'(bus4.busy), 32'h0);

        // Reset during DUMMY clears everything without waiting for an edge
        send_cmd(8'hEB);
        send_addr_mode(24'h000030);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        chk("pre_rst_busy",  32'(bus4.busy),     32'h1);
        chk("pre_rst_maddr", 32'(bus4.mem_addr), 32'h000030);
        #1;
        rst_n = 1'b0;
        #1;
        chk_cleared("async_rst");
        step(1'b1, 4'h0);
        rst_n = 1'b1;
        step(1'b1, 4'h0);
        send_cmd(8'hEB);
        send_addr_mode(24'h000031);
        dummy4();
        check_byte("after_rst", 8'h94);
        step(1'b1, 4'h0);

        // Dummy-length sweep: first nibble on cycles 17 / 20 / 31
        first1 = -1; first4 = -1; first15 = -1;
        send_cmd(8'hEB);
        send_addr_mode(24'h000040);
        repeat (17) step(1'b0, 4'h0);
        chk("sweep_d1_cycle",  32'(first1),  32'd17);
        chk("sweep_d4_cycle",  32'(first4),  32'd20);
        chk("sweep_d15_cycle", 32'(first15), 32'd31);
        chk("sweep_d1_nib",    32'(nib1),    32'hE);
        chk("sweep_d15_nib",   32'(nib15),   32'hE);
        step(1'b1, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
